// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the parallel-in/serial-out feeder: FSM state
// encoding and a constant clog2 used to size the bit counter.
package serial_bit_feeder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Smallest r with 2**r >= v; callers guarantee v >= 2 so r >= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// Serializes WIDTH-bit words onto a single-bit stream, one bit per clock,
// with zero-bubble reload on the last bit so consecutive words abut.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             A,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;

  logic w_shifting;
  logic w_at_last;
  logic w_accept;
  logic w_out_bit;

  assign w_shifting = (r_state == ST_SHIFT);
  assign w_at_last  = w_shifting && (r_cnt == LAST);
  assign load_ready = rst && (!w_shifting || w_at_last);
  assign w_accept   = load_valid && load_ready;

  // Outputs decode registered state only; nothing from din/load_valid reaches A.
  assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign A         = w_shifting ? w_out_bit : IDLE_BIT;
  assign bit_valid = w_shifting;
  assign last_bit  = w_at_last;
  assign busy      = w_shifting;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_cnt   <= '0;
      r_shreg <= din;
    end else if (w_shifting) begin
      if (w_at_last) begin
        r_state <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (MSB_FIRST) begin
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
          r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Randomized bench for serial_bit_feeder: a cycle-indexed schedule of
// expected bits is built from accepted words and compared every cycle.
module tb_serial_bit_feeder;

  localparam int W    = 8;
  localparam int NCYC = 8192;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         load_valid;

  logic ready_m, a_m, bv_m, lb_m, busy_m;
  logic ready_l, a_l, bv_l, lb_l, busy_l;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(ready_m), .A(a_m), .bit_valid(bv_m), .last_bit(lb_m), .busy(busy_m)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(ready_l), .A(a_l), .bit_valid(bv_l), .last_bit(lb_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Schedule: for cycle n, whether a word bit is on A, which word, and the
  // emission index of that bit within the word.
  bit           exp_v [NCYC];
  logic [W-1:0] exp_w [NCYC];
  int           exp_j [NCYC];

  bit armed = 1'b0;
  bit m_will_accept = 1'b0;

  // 101 counters over the MSB-first stream, enabled during the coupling test
  bit       det_en = 1'b0;
  bit [2:0] det_dut_hist, det_mod_hist;
  int       det_dut_cnt, det_mod_cnt;

  always @(negedge clk) begin
    bit           e_v, e_am, e_al, e_last, e_ready;
    logic [W-1:0] word;
    int           j;
    e_v  = (cyc < NCYC) ? exp_v[cyc] : 1'b0;
    word = (cyc < NCYC) ? exp_w[cyc] : '0;
    j    = (cyc < NCYC) ? exp_j[cyc] : 0;
    e_am    = e_v ? word[W-1-j] : 1'b0;
    e_al    = e_v ? word[j] : 1'b0;
    e_last  = e_v && (j == W - 1);
    e_ready = rst && (!e_v || e_last);
    if (armed) begin
      chk("msb_A",        32'(a_m),     32'(e_am));
      chk("msb_valid",    32'(bv_m),    32'(e_v));
      chk("msb_last",     32'(lb_m),    32'(e_last));
      chk("msb_busy",     32'(busy_m),  32'(e_v));
      chk("msb_ready",    32'(ready_m), 32'(e_ready));
      chk("lsb_A",        32'(a_l),     32'(e_al));
      chk("lsb_valid",    32'(bv_l),    32'(e_v));
      chk("lsb_last",     32'(lb_l),    32'(e_last));
      chk("lsb_ready",    32'(ready_l), 32'(e_ready));
      if (det_en) begin
        det_dut_hist = {det_dut_hist[1:0], a_m};
        det_mod_hist = {det_mod_hist[1:0], e_am};
        if (det_dut_hist == 3'b101) det_dut_cnt++;
        if (det_mod_hist == 3'b101) det_mod_cnt++;
      end
    end
    // Decide what the coming edge does
    m_will_accept = 1'b0;
    if (!rst) begin
      armed = 1'b1;
      for (int k = 1; k <= W; k++)
        if (cyc + k < NCYC) exp_v[cyc + k] = 1'b0;
    end else if (load_valid && e_ready) begin
      m_will_accept = 1'b1;
      for (int k = 0; k < W; k++) begin
        if (cyc + 1 + k < NCYC) begin
          exp_v[cyc + 1 + k] = 1'b1;
          exp_w[cyc + 1 + k] = din;
          exp_j[cyc + 1 + k] = k;
        end
      end
    end
  end

  // Offer a word; returns just after its accepting edge (cycle 1 of the word).
  task automatic send(input logic [W-1:0] w, input bit hold);
    bit ok;
    ok = 1'b0;
    din = w;
    load_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (m_will_accept) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: word %h not accepted within 100 cycles", w);
      load_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (!hold) load_valid = 1'b0;
      $display("[TB] accept word %h at cycle %0d", w, cyc);
    end
  endtask

  // Collect the 8 bits of the word now on A, first-emitted bit in the MSB.
  task automatic capture(output logic [W-1:0] cm, output logic [W-1:0] cl);
    cm = '0;
    cl = '0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk); #1;
      cm = {cm[W-2:0], a_m};
      cl = {cl[W-2:0], a_l};
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] cm, cl;
    rst = 1'b0;
    din = '0;
    load_valid = 1'b0;
    for (int i = 0; i < NCYC; i++) begin
      exp_v[i] = 1'b0;
      exp_w[i] = '0;
      exp_j[i] = 0;
    end
    idle(2);
    rst = 1'b1;
    idle(2);

    // Single word, both bit orders, with literal bit sequences
    send(8'b1010_0101, 1'b0);
    capture(cm, cl);
    chk("lit_msb_A5", 32'(cm), 32'h0000_00A5);
    chk("lit_lsb_A5", 32'(cl), 32'h0000_00A5);
    idle(3);
    send(8'b1100_0001, 1'b0);
    capture(cm, cl);
    chk("lit_msb_C1", 32'(cm), 32'h0000_00C1);
    chk("lit_lsb_C1", 32'(cl), 32'h0000_0083);
    idle(2);

    // Back-to-back: second word offered while the first is shifting
    send(8'hA5, 1'b1);
    send(8'h5A, 1'b0);
    capture(cm, cl);
    chk("lit_b2b_msb", 32'(cm), 32'h0000_005A);
    idle(3);

    // Stall: next word raised at cnt=3 of the current one
    send(8'h96, 1'b0);
    idle(3);
    send(8'h3C, 1'b0);
    idle(10);

    // Reset mid-word at cnt=4
    send(8'hFF, 1'b0);
    idle(4);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(3);

    // Detector coupling: 101 across the word boundary is preserved
    det_dut_hist = '0;
    det_mod_hist = '0;
    det_dut_cnt  = 0;
    det_mod_cnt  = 0;
    det_en = 1'b1;
    send(8'b0010_1010, 1'b1);
    send(8'b1000_0000, 1'b0);
    idle(W + 3);
    det_en = 1'b0;
    chk("det_101_count", 32'(det_dut_cnt), 32'(det_mod_cnt));

    // Randomized traffic with occasional resets
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 11) == 0) begin
        rst = 1'b0;
        idle($urandom_range(1, 2));
        rst = 1'b1;
        idle($urandom_range(0, 2));
      end else begin
        send(W'($urandom), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 10));
      end
    end
    load_valid = 1'b0;
    idle(W + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
